// File: rtl/csr_pkg.sv
// Shared types and constants for the CSR master initiator: FSM state encoding,
// CSR bus field widths and the default timeout budget.
package csr_pkg;

  localparam int CSR_SEL_W  = 16;
  localparam int CSR_ADDR_W = 16;
  localparam int CSR_DATA_W = 32;

  localparam int unsigned CSR_TIMEOUT_DEFAULT = 255;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQUEST   = 2'd1,
    WAIT_DATA = 2'd2,
    RESPOND   = 2'd3
  } csr_state_e;

endpackage

// File: rtl/csr_master_initiator_if.sv
// Host command/response ports plus the csr_request/csr_response bus of the
// initiator. master = initiator view, slave = host + CSR target view.
interface csr_master_initiator_if;
  import csr_pkg::*;

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_read_not_write;
  logic [CSR_SEL_W-1:0]  cmd_select;
  logic [CSR_ADDR_W-1:0] cmd_address;
  logic [CSR_DATA_W-1:0] cmd_data;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [CSR_DATA_W-1:0] rsp_read_data;
  logic                  rsp_timeout;

  logic                  csr_request__valid;
  logic                  csr_request__read_not_write;
  logic [CSR_SEL_W-1:0]  csr_request__select;
  logic [CSR_ADDR_W-1:0] csr_request__address;
  logic [CSR_DATA_W-1:0] csr_request__data;

  logic                  csr_response__ack;
  logic                  csr_response__read_data_valid;
  logic [CSR_DATA_W-1:0] csr_response__read_data;

  modport master (
    input  cmd_valid, cmd_read_not_write, cmd_select, cmd_address, cmd_data,
    input  rsp_ready,
    input  csr_response__ack, csr_response__read_data_valid, csr_response__read_data,
    output cmd_ready, rsp_valid, rsp_read_data, rsp_timeout,
    output csr_request__valid, csr_request__read_not_write, csr_request__select,
    output csr_request__address, csr_request__data
  );

  modport slave (
    output cmd_valid, cmd_read_not_write, cmd_select, cmd_address, cmd_data,
    output rsp_ready,
    output csr_response__ack, csr_response__read_data_valid, csr_response__read_data,
    input  cmd_ready, rsp_valid, rsp_read_data, rsp_timeout,
    input  csr_request__valid, csr_request__read_not_write, csr_request__select,
    input  csr_request__address, csr_request__data
  );

endinterface

// File: rtl/csr_master_initiator.sv
// Turns one host command at a time into a CSR bus transaction and returns the result.
// Optional abort timer compiled in with `define CSR_TIMEOUT_EN.
//
// state     | meaning
// IDLE      | cmd_ready=1, waiting for a host command
// REQUEST   | csr_request__valid=1 until the target acks
// WAIT_DATA | read acked, waiting for read_data_valid
// RESPOND   | rsp_valid=1 until the host takes the response
module csr_master_initiator
  import csr_pkg::*;
`ifdef CSR_TIMEOUT_EN
#(
  parameter int unsigned TIMEOUT_CYCLES = CSR_TIMEOUT_DEFAULT
)
`endif
(
  input logic clk,
  input logic reset,
  csr_master_initiator_if.master bus
);

  csr_state_e            state_q, state_d;
  logic                  rnw_q;
  logic [CSR_SEL_W-1:0]  sel_q;
  logic [CSR_ADDR_W-1:0] addr_q;
  logic [CSR_DATA_W-1:0] wdata_q;
  logic [CSR_DATA_W-1:0] rdata_q;
  logic                  accept;
  logic                  capture;
  logic                  cmd_ready_d, req_valid_d, rsp_valid_d;

  assign accept = bus.cmd_valid && (state_q == IDLE);

`ifdef CSR_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] tmo_cnt_q, tmo_cnt_d;
  logic        busy, expire, abort, timeout_q;

  assign busy   = (state_q == REQUEST) || (state_q == WAIT_DATA);
  assign expire = busy && (tmo_cnt_q == TMO_LAST);

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (accept)    tmo_cnt_d = '0;
    else if (busy) tmo_cnt_d = tmo_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      if (accept)     timeout_q <= 1'b0;
      else if (abort) timeout_q <= 1'b1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Completion is tested before expiry so a same-cycle completion wins.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
`ifdef CSR_TIMEOUT_EN
    abort   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (accept) state_d = REQUEST;
      end
      REQUEST: begin
        if (bus.csr_response__ack && (!rnw_q || bus.csr_response__read_data_valid)) begin
          state_d = RESPOND;
          capture = rnw_q;
`ifdef CSR_TIMEOUT_EN
        end else if (expire) begin
          state_d = RESPOND;
          abort   = 1'b1;
`endif
        end else if (bus.csr_response__ack) begin
          state_d = WAIT_DATA;
        end
      end
      WAIT_DATA: begin
        if (bus.csr_response__read_data_valid) begin
          state_d = RESPOND;
          capture = 1'b1;
`ifdef CSR_TIMEOUT_EN
        end else if (expire) begin
          state_d = RESPOND;
          abort   = 1'b1;
`endif
        end
      end
      RESPOND: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready_d = (state_q == IDLE);
    req_valid_d = (state_q == REQUEST);
    rsp_valid_d = (state_q == RESPOND);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rnw_q   <= 1'b0;
      sel_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        rnw_q   <= bus.cmd_read_not_write;
        sel_q   <= bus.cmd_select;
        addr_q  <= bus.cmd_address;
        wdata_q <= bus.cmd_data;
        rdata_q <= '0;
      end
      if (capture) rdata_q <= bus.csr_response__read_data;
    end
  end

  assign bus.cmd_ready                   = cmd_ready_d;
  assign bus.rsp_valid                   = rsp_valid_d;
  assign bus.rsp_read_data               = rdata_q;
  assign bus.csr_request__valid          = req_valid_d;
  assign bus.csr_request__read_not_write = rnw_q;
  assign bus.csr_request__select         = sel_q;
  assign bus.csr_request__address        = addr_q;
  assign bus.csr_request__data           = wdata_q;
`ifdef CSR_TIMEOUT_EN
  assign bus.rsp_timeout = timeout_q;
`else
  assign bus.rsp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_csr_master_initiator.sv
// Self-checking bench for csr_master_initiator: vector table of transactions with a
// response scoreboard, plus hand-written reset, spurious-input and timeout sequences.
module tb_csr_master_initiator;
  import csr_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  csr_master_initiator_if ifc ();

`ifdef CSR_TIMEOUT_EN
  csr_master_initiator #(.TIMEOUT_CYCLES(8)) dut (.clk(clk), .reset(reset), .bus(ifc.master));
`else
  csr_master_initiator dut (.clk(clk), .reset(reset), .bus(ifc.master));
`endif

  typedef struct {
    logic        rnw;
    logic [15:0] sel;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd_data;
    int          ack_dly;
    int          rd_dly;
    int          hold;
    bit          early_rdv;
    logic [31:0] exp_data;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic        tmo;
  } exp_t;

  vec_t vecs[6];
  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_err    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    ifc.cmd_valid                     = 1'b0;
    ifc.cmd_read_not_write            = 1'b0;
    ifc.cmd_select                    = '0;
    ifc.cmd_address                   = '0;
    ifc.cmd_data                      = '0;
    ifc.rsp_ready                     = 1'b0;
    ifc.csr_response__ack             = 1'b0;
    ifc.csr_response__read_data_valid = 1'b0;
    ifc.csr_response__read_data       = '0;
  endtask

  task automatic sb_pop_check(input string name);
    exp_t e;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_err++;
      $display("FAIL %s: response seen, scoreboard empty", name);
    end else begin
      e = sb_q.pop_front();
      chk({name, "_data"}, 64'(ifc.rsp_read_data), 64'(e.data));
      chk({name, "_tmo"}, 64'(ifc.rsp_timeout), 64'(e.tmo));
    end
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, "_cmd_ready"}, 64'(ifc.cmd_ready), 64'd1);
    chk({name, "_outs"},
        {ifc.rsp_valid, ifc.rsp_timeout, ifc.csr_request__valid,
         ifc.csr_request__read_not_write, ifc.rsp_read_data},
        64'd0);
    chk({name, "_req_fields"},
        {ifc.csr_request__select, ifc.csr_request__address, ifc.csr_request__data},
        64'd0);
  endtask

  task automatic send_cmd(input logic rnw, input logic [15:0] sel, input logic [15:0] addr,
                          input logic [31:0] wdata);
    ifc.cmd_valid          = 1'b1;
    ifc.cmd_read_not_write = rnw;
    ifc.cmd_select         = sel;
    ifc.cmd_address        = addr;
    ifc.cmd_data           = wdata;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int reqc = 0;
    int since_ack = 0;
    int cyc;
    bit acked = 0;
    exp_t e;
    @(negedge clk);
    chk("cmd_ready_idle", 64'(ifc.cmd_ready), 64'd1);
    send_cmd(v.rnw, v.sel, v.addr, v.wdata);
    e.data = v.exp_data;
    e.tmo  = 1'b0;
    sb_q.push_back(e);
    @(negedge clk);
    ifc.cmd_valid = 1'b0;
    for (cyc = 0; cyc < 200 && !ifc.rsp_valid; cyc++) begin
      ifc.csr_response__ack             = 1'b0;
      ifc.csr_response__read_data_valid = 1'b0;
      ifc.csr_response__read_data       = $urandom;
      if (ifc.csr_request__valid) begin
        reqc++;
        chk("req_rnw", 64'(ifc.csr_request__read_not_write), 64'(v.rnw));
        chk("req_fields",
            {ifc.csr_request__select, ifc.csr_request__address, ifc.csr_request__data},
            {v.sel, v.addr, v.wdata});
        if (reqc == v.ack_dly + 1) begin
          ifc.csr_response__ack = 1'b1;
          acked = 1;
          if (v.rnw && v.rd_dly == 0) begin
            ifc.csr_response__read_data_valid = 1'b1;
            ifc.csr_response__read_data       = v.rd_data;
          end
        end else if (v.early_rdv) begin
          ifc.csr_response__read_data_valid = 1'b1;
        end
      end else if (acked && v.rnw) begin
        since_ack++;
        if (since_ack == v.rd_dly) begin
          ifc.csr_response__read_data_valid = 1'b1;
          ifc.csr_response__read_data       = v.rd_data;
        end
      end
      @(negedge clk);
    end
    ifc.csr_response__ack             = 1'b0;
    ifc.csr_response__read_data_valid = 1'b0;
    chk($sformatf("v%0d_rsp_valid", idx), 64'(ifc.rsp_valid), 64'd1);
    if (!ifc.rsp_valid) begin
      void'(sb_q.pop_back());
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      return;
    end
    chk($sformatf("v%0d_req_cycles", idx), 64'(reqc), 64'(v.ack_dly + 1));
    chk($sformatf("v%0d_latency", idx), 64'(cyc),
        64'(v.ack_dly + 1 + (v.rnw ? v.rd_dly : 0)));
    for (int h = 0; h < v.hold; h++) begin
      chk("hold_rsp_valid", 64'(ifc.rsp_valid), 64'd1);
      chk("hold_cmd_ready", 64'(ifc.cmd_ready), 64'd0);
      chk("hold_rsp_data", 64'(ifc.rsp_read_data), 64'(v.exp_data));
      ifc.csr_response__ack             = 1'b1;
      ifc.csr_response__read_data_valid = 1'b1;
      ifc.csr_response__read_data       = $urandom;
      @(negedge clk);
    end
    ifc.csr_response__ack             = 1'b0;
    ifc.csr_response__read_data_valid = 1'b0;
    sb_pop_check($sformatf("v%0d_rsp", idx));
    ifc.rsp_ready = 1'b1;
    @(negedge clk);
    ifc.rsp_ready = 1'b0;
    chk("post_rsp_valid", 64'(ifc.rsp_valid), 64'd0);
    chk("post_cmd_ready", 64'(ifc.cmd_ready), 64'd1);
  endtask

`ifdef CSR_TIMEOUT_EN
  task automatic run_timeout(input bit complete_at_end);
    int reqc = 0;
    exp_t e;
    @(negedge clk);
    send_cmd(1'b1, 16'h0005, 16'h0040, 32'h0);
    e.data = complete_at_end ? 32'h600DF00D : 32'h0;
    e.tmo  = complete_at_end ? 1'b0 : 1'b1;
    sb_q.push_back(e);
    @(negedge clk);
    ifc.cmd_valid = 1'b0;
    for (int cyc = 0; cyc < 50 && !ifc.rsp_valid; cyc++) begin
      ifc.csr_response__ack             = 1'b0;
      ifc.csr_response__read_data_valid = 1'b0;
      if (ifc.csr_request__valid) reqc++;
      if (complete_at_end && reqc == 8) begin
        ifc.csr_response__ack             = 1'b1;
        ifc.csr_response__read_data_valid = 1'b1;
        ifc.csr_response__read_data       = 32'h600DF00D;
      end
      @(negedge clk);
    end
    ifc.csr_response__ack             = 1'b0;
    ifc.csr_response__read_data_valid = 1'b0;
    chk("tmo_req_cycles", 64'(reqc), 64'd8);
    chk("tmo_rsp_valid", 64'(ifc.rsp_valid), 64'd1);
    chk("tmo_req_dropped", 64'(ifc.csr_request__valid), 64'd0);
    sb_pop_check(complete_at_end ? "tmo_race" : "tmo");
    ifc.rsp_ready = 1'b1;
    @(negedge clk);
    ifc.rsp_ready = 1'b0;
    chk("tmo_post_cmd_ready", 64'(ifc.cmd_ready), 64'd1);
  endtask
`endif

  initial begin
    idle_inputs();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;

    //          rnw   sel       addr      wdata         rd_data       ack rd hold early exp
    vecs[0] = '{1'b0, 16'h0001, 16'h0010, 32'hDEADBEEF, 32'h0,        0, 0, 0, 1'b0, 32'h0};
    vecs[1] = '{1'b1, 16'h0002, 16'h0004, 32'h0,        32'h12345678, 1, 3, 0, 1'b0, 32'h12345678};
    vecs[2] = '{1'b1, 16'h0007, 16'h00FC, 32'h11112222, 32'hA5A5F00F, 0, 0, 5, 1'b0, 32'hA5A5F00F};
    vecs[3] = '{1'b0, 16'hFFFF, 16'hFFFE, 32'h01234567, 32'h0,        3, 0, 2, 1'b1, 32'h0};
    vecs[4] = '{1'b1, 16'h8000, 16'h0001, 32'h0,        32'h0BADCAFE, 2, 1, 0, 1'b1, 32'h0BADCAFE};
    vecs[5] = '{1'b1, 16'h0003, 16'h1234, 32'h0,        32'hFFFFFFFF, 2, 0, 1, 1'b0, 32'hFFFFFFFF};

    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

    // Spurious ack / read_data_valid while idle.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      ifc.csr_response__ack             = 1'b1;
      ifc.csr_response__read_data_valid = 1'b1;
      ifc.csr_response__read_data       = 32'hBAD0BAD0;
      if (i > 0) begin
        chk("spur_rsp_valid", 64'(ifc.rsp_valid), 64'd0);
        chk("spur_cmd_ready", 64'(ifc.cmd_ready), 64'd1);
        chk("spur_req_valid", 64'(ifc.csr_request__valid), 64'd0);
      end
    end
    @(negedge clk);
    idle_inputs();
    chk("spur_end_rsp_valid", 64'(ifc.rsp_valid), 64'd0);

    // Reset while waiting for read data.
    @(negedge clk);
    send_cmd(1'b1, 16'h0003, 16'h0020, 32'h0);
    @(negedge clk);
    ifc.cmd_valid = 1'b0;
    chk("rst_mid_req_valid", 64'(ifc.csr_request__valid), 64'd1);
    ifc.csr_response__ack = 1'b1;
    @(negedge clk);
    ifc.csr_response__ack = 1'b0;
    chk("rst_mid_in_wait", {ifc.csr_request__valid, ifc.rsp_valid, ifc.cmd_ready}, 64'd0);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("rst_mid");
    reset = 1'b0;
    @(negedge clk);
    ifc.csr_response__read_data_valid = 1'b1;
    ifc.csr_response__read_data       = 32'hCAFEF00D;
    @(negedge clk);
    ifc.csr_response__read_data_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("rst_mid_no_rsp", 64'(ifc.rsp_valid), 64'd0);
      chk("rst_mid_cmd_ready", 64'(ifc.cmd_ready), 64'd1);
      @(negedge clk);
    end

`ifdef CSR_TIMEOUT_EN
    run_timeout(1'b0);
    run_timeout(1'b1);
`else
    begin
      int req_low = 0;
      int rsp_seen = 0;
      @(negedge clk);
      send_cmd(1'b1, 16'h0005, 16'h0040, 32'h0);
      @(negedge clk);
      ifc.cmd_valid = 1'b0;
      for (int i = 0; i < 1000; i++) begin
        if (!ifc.csr_request__valid) req_low++;
        if (ifc.rsp_valid) rsp_seen++;
        @(negedge clk);
      end
      chk("noack_req_low_cycles", 64'(req_low), 64'd0);
      chk("noack_rsp_cycles", 64'(rsp_seen), 64'd0);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check_reset_outputs("noack_reset");
    end
`endif

    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
